avalon_ram_regioned: RTL

AVALON_RAM_REGIONED -- requirements
Module: avalon_ram_regioned

---
 rtl/avalon_ram_regioned.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/avalon_ram_regioned.sv
// rtl/avalon_ram_regioned.sv - Avalon-MM byte RAM with tagged address regions and waitstates
//
// Purpose:
//   Single-port Avalon-MM slave backed by a byte-addressed RAM of MEM_BYTES.
//   The top address byte selects a region tag.
//   - TAG1..TAG3 rebase the low address bits by OFF1..OFF3.
//   - Any other tag uses the low address bits directly.
//   Every access is stalled WAIT_CYCLES cycles with waitrequest.
//   Protocol errors latch a sticky fault flag.
//
// Optional feature (macro AVALON_RAM_TAG_CHECK_EN):
//   Accesses whose tag is not 8'h00, TAG1, TAG2 or TAG3 are faulted.
//   Such writes are dropped; such reads return 32'hDEADBEEF.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   address[31:0]  in   byte address; [31:24] is the region tag
//   read, write    in   commands, held while waitrequest is high
//   writedata[31:0], byteenable[3:0]  in   little-endian write data and lane enables
//   waitrequest    out  combinational stall
//   readdata[31:0], readdatavalid     out  registered read response
//   fault          out  sticky protocol-error flag

module avalon_ram_regioned #(
    parameter              RAM_FILE    = "",
    parameter int          MEM_BYTES   = 8192,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [7:0]  TAG1        = 8'h80,
    parameter logic [31:0] OFF1        = 32'h0000_0400,
    parameter logic [7:0]  TAG2        = 8'hBF,
    parameter logic [31:0] OFF2        = 32'h0000_1400,
    parameter logic [7:0]  TAG3        = 8'hFF,
    parameter logic [31:0] OFF3        = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        fault
);

    localparam int         AW       = $clog2(MEM_BYTES);
    localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);
    // Entering WAIT already accounts for the first stall cycle, so load WAIT_CYCLES-1.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic [7:0]  r_mem [0:MEM_BYTES-1];
    logic [31:0] r_readdata;
    logic        r_readdatavalid;
    logic        r_fault;

    logic [7:0]    w_tag;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_map;
    logic [AW-1:0] w_idx [4];
    logic [31:0]   w_rd_word;
    logic          w_cmd;
    logic          w_both;
    logic          w_accept;
    logic          w_misaligned;
    logic          w_tag_bad;
    logic          w_unused;

    // Memory image: zero everything.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            r_mem[i] = 8'h00;
        end
    end

    assign w_tag        = address[31:24];
    assign w_base       = address[AW-1:0];
    assign w_misaligned = (address[1:0] != 2'b00);
    // Address bits between the RAM window and the tag never affect the mapping.
    assign w_unused     = ^address[23:AW];

    // Region rebasing; the sum wraps naturally in AW bits.
    always_comb begin
        w_map = w_base;
        if (w_tag == TAG1) begin
            w_map = w_base + OFF1[AW-1:0];
        end else if (w_tag == TAG2) begin
            w_map = w_base + OFF2[AW-1:0];
        end else if (w_tag == TAG3) begin
            w_map = w_base + OFF3[AW-1:0];
        end
    end

    // Per-lane byte indices; a word straddling the top of memory wraps to byte 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_idx[i] = w_map + AW'(i);
        end
    end

    assign w_rd_word = {r_mem[w_idx[3]], r_mem[w_idx[2]], r_mem[w_idx[1]], r_mem[w_idx[0]]};

`ifdef AVALON_RAM_TAG_CHECK_EN
    assign w_tag_bad = !((w_tag == 8'h00) || (w_tag == TAG1) ||
                         (w_tag == TAG2)  || (w_tag == TAG3));
`else
    assign w_tag_bad = 1'b0;
`endif

    assign w_cmd  = read | write;
    assign w_both = read & write;

    // Gated by reset so the master sees the stall drop as soon as reset asserts.
    always_comb begin
        waitrequest = 1'b0;
        if (w_cmd && !reset) begin
            if (r_state == ST_IDLE) begin
                waitrequest = HAS_WAIT;
            end else begin
                waitrequest = (r_cnt != 4'd0);
            end
        end
    end

    // Conflicting read+write is never accepted, so it has no memory effect.
    assign w_accept = w_cmd & ~w_both & ~waitrequest & ~reset;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd && !w_both && HAS_WAIT) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!w_cmd || w_both) begin
                    // Master withdrew (abort) or issued an illegal command.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    // Accept edge.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Memory has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && write && !w_tag_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    r_mem[w_idx[i]] <= writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata      <= 32'h0000_0000;
            r_readdatavalid <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_readdatavalid <= w_accept & read;
            if (w_accept && read) begin
                r_readdata <= w_tag_bad ? 32'hDEAD_BEEF : w_rd_word;
            end
            if (w_both || (w_accept && (w_misaligned || w_tag_bad))) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign fault         = r_fault;

endmodule
